bcd_to_binary_seq: RTL and testbench

//  Sequential BCD-to-binary converter using reverse double-dabble: shift right, then subtract 3 from every digit >= 8.

---
 rtl/bcd_pkg.sv | 27 ++
 rtl/bcd_digit_adjust.sv | 11 +
 rtl/bcd_to_binary_seq.sv | 120 ++++++++++++
 tb/tb_bcd_to_binary_seq.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD constants, FSM encoding and width helper for the BCD <-> binary paths.
package bcd_pkg;

    localparam int         BCD_DIGIT_W   = 4;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD_CHK,
        ST_CONV,
        ST_DONE
    } bcd_state_t;

    // Smallest w with 2^w >= 10^digits, i.e. enough bits for 10^digits - 1.
    function automatic int min_bin_w(input int digits);
        logic [127:0] lim;
        int           w;
        lim = 128'd1;
        for (int i = 0; i < digits; i++) lim = lim * 128'd10;
        w = 0;
        for (int i = 0; i < 127; i++) begin
            if ((128'd1 << i) < lim) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One-digit reverse double-dabble correction: digits of 8 or more lose 3 after the right shift.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    assign digit_o = (digit_i >= 4'd8) ? digit_i - 4'd3 : digit_i;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one result bit per clock,
// with a start/busy/done handshake and an error flag for non-decimal digits.
module bcd_to_binary_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 12,
    parameter int BIN_W  = 40
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [BIN_W-1:0]              binary_out
);

    localparam int DW    = BCD_DIGIT_W * DIGITS;
    localparam int SH_W  = DW + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    if (BIN_W < min_bin_w(DIGITS)) begin : g_bad_width
        $error("bcd_to_binary_seq: BIN_W too small for DIGITS");
    end

    bcd_state_t       state_q;
    logic [DW-1:0]    digits_q;
    logic [BIN_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic [BIN_W-1:0] bin_q;

    logic [SH_W-1:0]  shifted_d;
    logic [DW-1:0]    dig_shift_d;
    logic [DW-1:0]    dig_adj_d;
    logic [BIN_W-1:0] acc_d;
    logic             bad_digit;
    logic             last_iter;

    // Digits and accumulator form one long register; digit 0's LSB drops into the acc MSB.
    assign shifted_d   = {digits_q, acc_q} >> 1;
    assign dig_shift_d = shifted_d[SH_W-1:BIN_W];
    assign acc_d       = shifted_d[BIN_W-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_i (dig_shift_d[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (dig_adj_d[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digits_q[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT) bad_digit = 1'b1;
        end
    end

    assign last_iter = (cnt_q == CNT_W'(BIN_W - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            digits_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            bin_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        digits_q <= bcd_in;
                        err_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_LOAD_CHK;
                    end
                end
                ST_LOAD_CHK: begin
                    if (bad_digit) begin
                        err_q   <= 1'b1;
                        bin_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    digits_q <= dig_adj_d;
                    acc_q    <= acc_d;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        bin_q   <= acc_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign binary_out = bin_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Randomized self-checking bench for bcd_to_binary_seq against a decimal-arithmetic model.
module tb_bcd_to_binary_seq;

    localparam int DIGITS = 12;
    localparam int BIN_W  = 40;
    localparam int VLAT   = BIN_W + 1;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [4*DIGITS-1:0] bcd_in = '0;
    logic              busy, done, err;
    logic [BIN_W-1:0]  binary_out;

    int total = 0;
    int bad   = 0;

    bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .bcd_in     (bcd_in),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .binary_out (binary_out)
    );

    always #5 clock = ~clock;

    function automatic logic [BIN_W-1:0] model_bin(input logic [4*DIGITS-1:0] b);
        longint unsigned v;
        v = 0;
        for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + longint'(b[i*4 +: 4]);
        return v[BIN_W-1:0];
    endfunction

    function automatic bit model_bad(input logic [4*DIGITS-1:0] b);
        for (int i = 0; i < DIGITS; i++) if (b[i*4 +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [4*DIGITS-1:0] rand_bcd();
        logic [4*DIGITS-1:0] b;
        for (int i = 0; i < DIGITS; i++) b[i*4 +: 4] = 4'($urandom_range(0, 9));
        return b;
    endfunction

    // Accept one start, optionally pulse a second start at edge inj_k, and wait for done.
    task automatic run_conv(input logic [4*DIGITS-1:0] b, input int inj_k,
                            input logic [4*DIGITS-1:0] inj_b,
                            output logic [BIN_W-1:0] bin, output logic e,
                            output int lat, output logic bsy);
        @(negedge clock);
        bcd_in = b;
        start  = 1'b1;
        @(posedge clock);
        #1;
        bsy = busy;
        lat = -1;
        bin = '0;
        e   = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clock);
            start  = (k == inj_k);
            bcd_in = (k == inj_k) ? inj_b : 48'({$urandom, $urandom});
            @(posedge clock);
            #1;
            if (done) begin
                lat = k;
                bin = binary_out;
                e   = err;
                break;
            end
        end
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clock);
            #1;
            total++;
            if ({busy, done, err, binary_out} !== {3'b000, {BIN_W{1'b0}}}) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got busy=%b done=%b err=%b bin=%h want all 0",
                         c, busy, done, err, binary_out);
            end
        end
    endtask

    task automatic test_basic();
        logic [BIN_W-1:0] bin; logic e, bsy; int lat;
        run_conv(48'h000000000255, 0, '0, bin, e, lat, bsy);
        total++;
        if (bsy !== 1'b1) begin bad++; $display("FAIL basic_busy got %b want 1", bsy); end
        total++;
        if (bin !== 40'h00000000FF) begin bad++; $display("FAIL basic_255 got %h want %h", bin, 40'hFF); end
        total++;
        if (e !== 1'b0) begin bad++; $display("FAIL basic_err got %b want 0", e); end
        total++;
        if (lat !== VLAT) begin bad++; $display("FAIL basic_latency got %0d want %0d", lat, VLAT); end
        @(posedge clock);
        #1;
        total++;
        if (done !== 1'b0 || bin !== binary_out) begin
            bad++;
            $display("FAIL basic_pulse got done=%b bin=%h want done=0 bin=%h", done, binary_out, bin);
        end
    endtask

    task automatic test_extremes();
        logic [BIN_W-1:0] bin; logic e, bsy; int lat;
        run_conv(48'h999999999999, 0, '0, bin, e, lat, bsy);
        total++;
        if (bin !== 40'hE8D4A50FFF || e !== 1'b0) begin
            bad++; $display("FAIL max_value got %h err=%b want %h err=0", bin, e, 40'hE8D4A50FFF);
        end
        run_conv(48'h000000000000, 0, '0, bin, e, lat, bsy);
        total++;
        if (bin !== 40'h0 || e !== 1'b0) begin
            bad++; $display("FAIL zero_value got %h err=%b want 0 err=0", bin, e);
        end
    endtask

    task automatic test_invalid();
        logic [BIN_W-1:0] bin; logic e, bsy; int lat;
        run_conv(48'h00000000001A, 0, '0, bin, e, lat, bsy);
        total++;
        if (e !== 1'b1 || bin !== '0) begin
            bad++; $display("FAIL invalid_result got err=%b bin=%h want err=1 bin=0", e, bin);
        end
        total++;
        if (lat !== 1) begin bad++; $display("FAIL invalid_latency got %0d want 1", lat); end
        repeat (3) @(posedge clock);
        #1;
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got %b want 1", err); end
        @(negedge clock);
        bcd_in = 48'h000000000042;
        start  = 1'b1;
        @(posedge clock);
        #1;
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL err_clear_on_start got %b want 0", err); end
        @(negedge clock);
        start = 1'b0;
        repeat (VLAT + 2) @(posedge clock);
        #1;
        total++;
        if (binary_out !== 40'd42 || err !== 1'b0) begin
            bad++; $display("FAIL after_err_value got %h err=%b want 2a err=0", binary_out, err);
        end
    endtask

    task automatic test_ignored_start();
        logic [BIN_W-1:0] bin; logic e, bsy; int lat; int extra;
        run_conv(48'h000000001234, 10, 48'h000000005678, bin, e, lat, bsy);
        total++;
        if (bin !== 40'h4D2 || lat !== VLAT) begin
            bad++; $display("FAIL ignored_start got %h lat=%0d want 4d2 lat=%0d", bin, lat, VLAT);
        end
        extra = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clock);
            #1;
            if (done) extra++;
        end
        total++;
        if (extra !== 0) begin bad++; $display("FAIL ignored_not_queued got %0d dones want 0", extra); end
    endtask

    task automatic test_reset_abort();
        int extra;
        @(negedge clock);
        bcd_in = 48'h000000009876;
        start  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        total++;
        if ({busy, done, err, binary_out} !== {3'b000, {BIN_W{1'b0}}}) begin
            bad++;
            $display("FAIL abort_state got busy=%b done=%b err=%b bin=%h want all 0", busy, done, err, binary_out);
        end
        @(negedge clock);
        reset = 1'b0;
        extra = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clock);
            #1;
            if (done || busy) extra++;
        end
        total++;
        if (extra !== 0) begin bad++; $display("FAIL abort_no_done got %0d active cycles want 0", extra); end
    endtask

    task automatic test_back_to_back();
        int n; logic [BIN_W-1:0] r[2]; int at[2];
        n = 0;
        r[0] = '0; r[1] = '0; at[0] = -1; at[1] = -1;
        @(negedge clock);
        bcd_in = 48'h000000001234;
        start  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bcd_in = 48'h000000005678;
        for (int k = 1; k <= 120; k++) begin
            @(posedge clock);
            #1;
            if (done) begin
                if (n < 2) begin r[n] = binary_out; at[n] = k; end
                n++;
            end
            if (k == 2 * VLAT + 1) begin
                @(negedge clock);
                start = 1'b0;
            end
        end
        start = 1'b0;
        total++;
        if (n !== 2) begin bad++; $display("FAIL b2b_count got %0d want 2", n); end
        total++;
        if (r[0] !== 40'h4D2 || r[1] !== 40'h162E) begin
            bad++; $display("FAIL b2b_values got %h,%h want 4d2,162e", r[0], r[1]);
        end
        total++;
        if (at[0] !== VLAT || at[1] !== 2 * VLAT + 2) begin
            bad++; $display("FAIL b2b_timing got %0d,%0d want %0d,%0d", at[0], at[1], VLAT, 2 * VLAT + 2);
        end
    endtask

    task automatic test_random();
        logic [BIN_W-1:0] bin; logic e, bsy; int lat;
        logic [4*DIGITS-1:0] b;
        logic [BIN_W-1:0] exp_bin; bit exp_err; int exp_lat;
        for (int t = 0; t < 1500; t++) begin
            b = rand_bcd();
            if ($urandom_range(0, 7) == 0) b[$urandom_range(0, DIGITS - 1) * 4 +: 4] = 4'($urandom_range(10, 15));
            exp_err = model_bad(b);
            exp_bin = exp_err ? '0 : model_bin(b);
            exp_lat = exp_err ? 1 : VLAT;
            run_conv(b, 0, '0, bin, e, lat, bsy);
            total++;
            if (bin !== exp_bin || e !== exp_err || lat !== exp_lat) begin
                bad++;
                $display("FAIL random bcd=%h got bin=%h err=%b lat=%0d want bin=%h err=%b lat=%0d",
                         b, bin, e, lat, exp_bin, exp_err, exp_lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_invalid();
        test_ignored_start();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
